// File: rtl/mt19937_stream_arbiter_if.sv
// mt19937_stream_arbiter_if: consumer-side stream bundle shared by the random-number consumers
interface mt19937_stream_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic [NUM_REQ-1:0]    m_tvalid;
  logic [NUM_REQ-1:0]    m_tready;
  logic                  m_tlast;
  modport master (input req, m_tready, output grant, m_tdata, m_tvalid, m_tlast);
  modport slave  (output req, m_tready, input grant, m_tdata, m_tvalid, m_tlast);
endinterface

// File: rtl/mt19937_stream_arbiter.sv
// mt19937_stream_arbiter: seeds a shared MT19937 generator, then round-robins its stream across consumers in bursts
module mt19937_stream_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_seed_req,
  input  logic [31:0]           cfg_seed_val,
  output logic                  cfg_seed_ack,
  output logic                  seeding,
  output logic                  gen_seed_start,
  output logic [31:0]           gen_seed_val,
  input  logic                  gen_busy,
  input  logic [DATA_WIDTH-1:0] gen_tdata,
  input  logic                  gen_tvalid,
  output logic                  gen_tready,
  mt19937_stream_arbiter_if.master cons
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  typedef enum logic [2:0] {UNSEEDED, SEED_PULSE, SEED_WAIT, ARB, BURST} state_t;
  state_t state_q, state_d;
  logic seed_pend_q, seed_pend_d;
  logic [31:0] seed_reg_q, seed_reg_d;
  logic wait_q;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] last_q, last_d, g_q, g_d, pick;
  logic [IW:0] k;
  logic [NUM_REQ-1:0] grant_q;
  logic ack_q, ack_d, start_q, seeding_q;
  logic found, in_burst, beat, pend, done;
  assign cons.m_tdata   = gen_tdata;
  assign cons.grant     = grant_q;
  assign cfg_seed_ack   = ack_q;
  assign gen_seed_start = start_q;
  assign gen_seed_val   = seed_reg_q;
  assign seeding        = seeding_q;
  // round-robin search for the first requester after the previous owner
  always_comb begin
    pick = last_q;
    found = 1'b0;
    k = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (IW+1)'(last_q) + (IW+1)'(i);
      k = k >= (IW+1)'(NUM_REQ) ? k - (IW+1)'(NUM_REQ) : k;
      if (!found && cons.req[k[IW-1:0]]) begin
        pick = k[IW-1:0];
        found = 1'b1;
      end
    end
  end
  // sequencer next state plus the stream-side combinational outputs
  always_comb begin
    state_d = state_q;
    seed_reg_d = cfg_seed_req ? cfg_seed_val : seed_reg_q;
    pend = seed_pend_q | cfg_seed_req;
    beat_cnt_d = beat_cnt_q;
    last_d = last_q;
    g_d = g_q;
    ack_d = 1'b0;
    in_burst = state_q == BURST;
    beat = in_burst & gen_tvalid & cons.m_tready[g_q];
    done = in_burst & (beat ? beat_cnt_q == LAST_BEAT : !cons.req[g_q]);
    gen_tready = in_burst & cons.m_tready[g_q];
    cons.m_tvalid = in_burst & gen_tvalid ? grant_q : '0;
    cons.m_tlast = in_burst & (beat_cnt_q == LAST_BEAT);
    case (state_q)
      UNSEEDED:   state_d = pend ? SEED_PULSE : UNSEEDED;
      SEED_PULSE: state_d = SEED_WAIT;
      SEED_WAIT:  if (wait_q && !gen_busy) begin
                    state_d = ARB;
                    ack_d = 1'b1;
                  end
      ARB:        if (pend) state_d = SEED_PULSE;
                  else if (found) begin
                    state_d = BURST;
                    g_d = pick;
                  end
      BURST:      if (done) begin
                    state_d = ARB;
                    last_d = g_q;
                    beat_cnt_d = '0;
                  end else if (beat) beat_cnt_d = beat_cnt_q + CW'(1);
      default:    state_d = UNSEEDED;
    endcase
    seed_pend_d = (state_d == SEED_PULSE && state_q != SEED_PULSE) ? 1'b0 : pend;
  end
  // state and registered outputs; reset leaves the generator unseeded with consumer 0 first in line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSEEDED;
      seed_pend_q <= 1'b0;
      seed_reg_q <= '0;
      wait_q <= 1'b0;
      beat_cnt_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      g_q <= '0;
      grant_q <= '0;
      ack_q <= 1'b0;
      start_q <= 1'b0;
      seeding_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_pend_q <= seed_pend_d;
      seed_reg_q <= seed_reg_d;
      wait_q <= state_q == SEED_WAIT;
      beat_cnt_q <= beat_cnt_d;
      last_q <= last_d;
      g_q <= g_d;
      grant_q <= state_d == BURST ? NUM_REQ'(1) << g_d : '0;
      ack_q <= ack_d;
      start_q <= state_d == SEED_PULSE;
      seeding_q <= state_d == SEED_PULSE || state_d == SEED_WAIT;
    end
  end
endmodule

// File: tb/tb_mt19937_stream_arbiter.sv
// tb_mt19937_stream_arbiter: generator model feeds a word scoreboard; directed phases check seeding, arbitration and bursts
module tb_mt19937_stream_arbiter;
  localparam int NR = 4;
  localparam int BL = 16;
  logic clk = 0, rst_n = 0, cfg_seed_req = 0;
  logic [31:0] cfg_seed_val = 0, exp_seed = 0;
  logic cfg_seed_ack, seeding, gen_seed_start, gen_busy, gen_tvalid, gen_tready;
  logic [31:0] gen_seed_val, gen_tdata, gseed;
  int gidx, bcnt;
  int n_tests = 0, n_fail = 0, words = 0;
  logic [31:0] sbq[$];
  mt19937_stream_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(32)) bus();
  mt19937_stream_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_seed_req(cfg_seed_req), .cfg_seed_val(cfg_seed_val),
    .cfg_seed_ack(cfg_seed_ack), .seeding(seeding), .gen_seed_start(gen_seed_start),
    .gen_seed_val(gen_seed_val), .gen_busy(gen_busy), .gen_tdata(gen_tdata),
    .gen_tvalid(gen_tvalid), .gen_tready(gen_tready), .cons(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] s, input int i);
    return (s ^ 32'h5bd1e995) * 32'(i + 1) + 32'(i) * 32'h9e3779b9;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // generator model: busy for 5 cycles after a seed pulse, then an endless AXI stream; every new word goes to the scoreboard
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_busy <= 0; gen_tvalid <= 1; bcnt <= 0; gseed <= 0; gidx <= 0;
      gen_tdata <= word(32'd0, 0);
      sbq.delete(); sbq.push_back(word(32'd0, 0));
    end else if (gen_seed_start) begin
      gen_busy <= 1; gen_tvalid <= 0; bcnt <= 5; gseed <= gen_seed_val; gidx <= 0;
      sbq.delete();
    end else if (gen_busy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        gen_busy <= 0; gen_tvalid <= 1;
        gen_tdata <= word(gseed, 0); sbq.push_back(word(gseed, 0));
      end
    end else if (gen_tvalid && gen_tready) begin
      gidx <= gidx + 1;
      gen_tdata <= word(gseed, gidx + 1); sbq.push_back(word(gseed, gidx + 1));
    end
  end
  // consumer-side monitor: each delivered beat must be the next generator word and go to the owner
  always @(negedge clk) if (rst_n) begin
    for (int i = 0; i < NR; i++) if (bus.m_tvalid[i] && bus.m_tready[i]) begin
      words++;
      chk("beat_owner", 32'(bus.grant[i]), 1);
      if (sbq.size() == 0) chk("sb_empty", 32'(sbq.size()), 1);
      else chk("data", bus.m_tdata, sbq.pop_front());
    end
    chk("gen_tready", 32'(gen_tready), 32'(|(bus.grant & bus.m_tready)));
    if (gen_seed_start) begin
      chk("seed_val", gen_seed_val, exp_seed);
      chk("seeding", 32'(seeding), 1);
    end
  end
  task automatic chk_reset_outs(input string t);
    chk({t, "_grant"}, 32'(bus.grant), 0);
    chk({t, "_m_tvalid"}, 32'(bus.m_tvalid), 0);
    chk({t, "_m_tlast"}, 32'(bus.m_tlast), 0);
    chk({t, "_gen_tready"}, 32'(gen_tready), 0);
    chk({t, "_seed_start"}, 32'(gen_seed_start), 0);
    chk({t, "_seed_val"}, gen_seed_val, 0);
    chk({t, "_ack"}, 32'(cfg_seed_ack), 0);
    chk({t, "_seeding"}, 32'(seeding), 0);
  endtask
  task automatic wait_ack(input bit chk_lat);
    int t = 0, pulses = 0;
    while (t < 100) begin
      @(negedge clk); t++;
      pulses += int'(gen_seed_start);
      chk("grant_in_seed", 32'(bus.grant), 0);
      if (cfg_seed_ack) break;
    end
    chk("ack_seen", 32'(cfg_seed_ack), 1);
    chk("seed_pulses", 32'(pulses), 1);
    chk("ack_busy", 32'(gen_busy), 0);
    if (chk_lat) chk("ack_latency_ge4", 32'(t >= 4), 1);
  endtask
  task automatic do_seed(input logic [31:0] v);
    cfg_seed_val = v; exp_seed = v; cfg_seed_req = 1;
    @(posedge clk); #1 cfg_seed_req = 0;
    wait_ack(1);
  endtask
  task automatic run_burst(input int eg, input int nb, input int el, input int abort_at,
                           input int seed_at, input bit toggle, input bit chk_gap);
    int beats = 0, lasts = 0, t = 0;
    bit fin = 0, sent = 0;
    @(negedge clk);
    while (bus.grant == 0 && t < 100) begin @(negedge clk); t++; end
    if (chk_gap) chk("gap", 32'(t), 0);
    chk("grant", 32'(bus.grant), 32'(1) << eg);
    while (bus.grant != 0 && t < 400) begin
      if (bus.m_tvalid[eg] && bus.m_tready[eg]) begin
        beats++; lasts += int'(bus.m_tlast); fin = bus.m_tlast;
      end
      @(posedge clk); #1;
      if (beats == abort_at) begin bus.req[eg] = 0; bus.m_tready[eg] = 0; end
      cfg_seed_req = beats == seed_at && !sent;
      if (cfg_seed_req) begin sent = 1; exp_seed = cfg_seed_val; end
      if (toggle) bus.m_tready = ~bus.m_tready;
      @(negedge clk); t++;
    end
    chk("burst_end", 32'(t < 400), 1);
    chk("beats", 32'(beats), 32'(nb));
    chk("tlast_cnt", 32'(lasts), 32'(el));
    chk("tlast_final", 32'(fin), 32'(el));
  endtask
  initial begin
    int nxt, w0, nbursts, t;
    bus.req = '0; bus.m_tready = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1 rst_n = 1;
    bus.req = '1; bus.m_tready = '1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("gate_m_tvalid", 32'(bus.m_tvalid), 0);
      chk("gate_gen_tready", 32'(gen_tready), 0);
      chk("gate_grant", 32'(bus.grant), 0);
    end
    @(posedge clk); #1;
    do_seed(32'd19650218);
    run_burst(0, BL, 1, -1, -1, 0, 1);
    for (int g = 1; g <= 4; g++) run_burst(g % NR, BL, 1, -1, -1, 0, 1);
    nxt = 1; w0 = words; nbursts = 0;
    while (words - w0 < 10000 && nbursts < 700) begin
      run_burst(nxt, BL, 1, -1, -1, 1, 1);
      nxt = (nxt + 1) % NR; nbursts++;
    end
    chk("bp_words", 32'(words - w0), 32'(nbursts * BL));
    chk("bp_enough", 32'(words - w0 >= 10000), 1);
    bus.m_tready = '1;
    while (nxt != 1 && nbursts < 710) begin
      run_burst(nxt, BL, 1, -1, -1, 0, 1);
      nxt = (nxt + 1) % NR; nbursts++;
    end
    run_burst(1, 5, 0, 5, -1, 0, 1);
    run_burst(2, BL, 1, -1, -1, 0, 1);
    bus.req[1] = 1; bus.m_tready[1] = 1;
    cfg_seed_val = 32'hc0ffee11;
    run_burst(3, BL, 1, -1, 3, 0, 1);
    wait_ack(0);
    run_burst(0, BL, 1, -1, -1, 0, 1);
    t = 0;
    while (bus.grant == 0 && t < 100) begin @(negedge clk); t++; end
    chk("pre_rst_grant", 32'(bus.grant != 0), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 chk_reset_outs("arst");
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_rst_grant", 32'(bus.grant), 0);
      chk("post_rst_m_tvalid", 32'(bus.m_tvalid), 0);
    end
    @(posedge clk); #1;
    do_seed(32'd5489);
    run_burst(0, BL, 1, -1, -1, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mt19937_stream_arbiter.md
# mt19937_stream_arbiter

Sequencer and round-robin arbiter that shares one `axis_mt19937` generator among NUM_REQ AXI-Stream consumers. It owns the generator's seeding port, so no consumer receives a word before the generator has been seeded. After seeding, it grants the output stream to one requester at a time in fixed-length bursts. It sits between the generator instance and the random-number consumers.

## Interface
- NUM_REQ, 4: number of consumers (2..16).
- BURST_LEN, 16: words per grant (1..1024).
- DATA_WIDTH, 32: stream word width; must match the generator.

- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_seed_req  in  1  one-cycle request to (re)seed the generator.
- cfg_seed_val  in  32  seed value, sampled when cfg_seed_req=1.
- cfg_seed_ack  out  1  one-cycle pulse when seeding completes.
- seeding  out  1  high in SEED_PULSE and SEED_WAIT.
- gen_seed_start  out  1  to generator `seed_start`.
- gen_seed_val  out  32  to generator `seed_val`.
- gen_busy  in  1  from generator `busy`.
- gen_tdata  in  DATA_WIDTH  from generator stream.
- gen_tvalid  in  1  from generator stream.
- gen_tready  out  1  to generator stream.
- req  in  NUM_REQ  per-consumer request level.
- grant  out  NUM_REQ  one-hot (or zero) current owner.
- m_tdata  out  DATA_WIDTH  shared data, equals gen_tdata combinationally.
- m_tvalid  out  NUM_REQ  per-consumer valid.
- m_tready  in  NUM_REQ  per-consumer ready.
- m_tlast  out  1  high on the final beat of a burst.

## Operation
- States: UNSEEDED, SEED_PULSE, SEED_WAIT, ARB, BURST. Reset enters UNSEEDED.
- Seed capture:
  - cfg_seed_req=1 in any state sets seed_pend and loads seed_reg←cfg_seed_val. The latest request wins.
  - seed_pend clears on entry to SEED_PULSE.
- UNSEEDED: goes to SEED_PULSE when seed_pend=1, or cfg_seed_req=1 this cycle. req is ignored.
- SEED_PULSE:
  - Lasts exactly 1 cycle.
  - gen_seed_start=1 and gen_seed_val=seed_reg.
  - Goes to SEED_WAIT.
- SEED_WAIT:
  - Stays at least 2 cycles, then leaves on the first cycle with gen_busy=0.
  - On leaving, pulses cfg_seed_ack and goes to ARB.
- ARB:
  - If seed_pend=1, go to SEED_PULSE. Seeding has priority over new grants.
  - Else, if req≠0, pick the first set bit searching upward from (last+1) mod NUM_REQ. Register grant and go to BURST.
  - Else, stay in ARB.
- BURST, with granted index g:
  - gen_tready=m_tready[g]; m_tvalid[g]=gen_tvalid; every other m_tvalid bit is 0.
  - A beat is gen_tvalid & m_tready[g]. Each beat increments beat_cnt.
  - m_tlast=1 when beat_cnt==BURST_LEN-1.
  - On the last beat: last←g, clear grant, reset beat_cnt, go to ARB.
  - Early exit: if req[g]=0 in a cycle with no beat, the burst aborts with the same actions.
- seed_pend set during a burst does not interrupt it. It is serviced at the next ARB.
- Outside BURST: gen_tready=0, m_tvalid=0, m_tlast=0, grant=0.
- beat_cnt width is clog2(BURST_LEN), minimum 1. With BURST_LEN=1, m_tlast=1 for the whole burst.

## Timing
- Reset values:
  - Outputs: grant=0, m_tvalid=0, m_tlast=0, gen_tready=0, gen_seed_start=0, gen_seed_val=0, cfg_seed_ack=0, seeding=0.
  - Internal: seed_pend=0, beat_cnt=0, last=NUM_REQ-1, so consumer 0 has first priority.
- Async reset mid-burst or mid-seed returns to UNSEEDED. A reseed is then required before any grant.
- Seed latency: cfg_seed_req at cycle N (in UNSEEDED or ARB) gives SEED_PULSE at N+1. cfg_seed_ack comes no earlier than N+4.
- Arbitration latency: req seen in ARB at cycle N gives grant and the first possible beat at N+1.
- Burst to next grant: there is a 1-cycle ARB bubble between consecutive bursts.
- All outputs are registered, except m_tdata, m_tvalid, gen_tready and m_tlast.
- Those four are combinational from grant/state and the stream inputs; no other combinational path exists.

## Test plan
- Seed gate:
  - Stimulus: req=4'b1111 with no seed for 50 cycles, then cfg_seed_req with cfg_seed_val=19650218.
  - Required: m_tvalid=0 and gen_tready=0 throughout the first 50 cycles.
  - Required: one gen_seed_start pulse carrying 19650218, cfg_seed_ack after gen_busy falls, then grant=4'b0001.
- Round-robin:
  - Stimulus: all req high, m_tready=1, BURST_LEN=16, continuous gen_tvalid.
  - Required: grants in order 0,1,2,3,0. Each burst has 16 beats, m_tlast on beat 16, and one bubble cycle between bursts.
- Backpressure:
  - Stimulus: m_tready[g] toggles 1010.
  - Required: gen_tready mirrors m_tready[g]. Beat count and data order match the generator output sequence exactly, with no word dropped or duplicated across 10000 words.
- Early abort:
  - Stimulus: req[1] drops after 5 beats.
  - Required: the burst ends with no m_tlast and the next grant goes to 2.
- Reseed mid-burst:
  - Stimulus: cfg_seed_req at beat 3 of 16.
  - Required: the burst completes all 16 beats, then SEED_PULSE follows, and the next grant comes only after cfg_seed_ack.
- Reset mid-burst:
  - Stimulus: rst_n low asynchronously for 1 cycle during BURST.
  - Required: all outputs return to their reset values immediately, and no grant occurs until a new seed completes.
